// File: rtl/fwft_fifo.sv
// First-word-fall-through synchronous FIFO: dual-port RAM with a registered read,
// a one-word output stage, depth-sized count/avail, threshold flags and sticky errors.
module fwft_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 512,
  parameter int AF_THRESH = DEPTH - 10,
  parameter int AE_THRESH = 2,
  localparam int CB       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CB:0]      count,
  output logic [CB:0]      avail,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clear
);

  localparam logic [CB:0] DEPTH_C = (CB+1)'(DEPTH);
  localparam logic [CB:0] AF_C    = (CB+1)'(AF_THRESH);
  localparam logic [CB:0] AE_C    = (CB+1)'(AE_THRESH);
  localparam logic [CB:0] ONE_C   = (CB+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CB-1:0]    wr_ptr_p0, rd_ptr_p0;
  logic [CB:0]      ram_cnt_p0;
  logic [WIDTH-1:0] ram_data_p1;
  logic             vld_p1;

  logic wr_acc, rd_acc, out_free, fetch;

  assign wr_acc   = wr_en && !full;
  assign rd_acc   = rd_en && rd_valid;
  assign out_free = !rd_valid || rd_acc;
  // ram_cnt_p0 counts words still in RAM and not yet launched into the read stage
  assign fetch    = (ram_cnt_p0 != '0) && out_free;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign avail        = DEPTH_C - count;

  // p0 -> RAM: write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_acc && !clear) mem[wr_ptr_p0] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (fetch && !clear) ram_data_p1 <= mem[rd_ptr_p0];
  end

  // p1 -> output stage, plus pointer/count/flag control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_p0  <= '0;
      rd_ptr_p0  <= '0;
      ram_cnt_p0 <= '0;
      vld_p1     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr_p0  <= '0;
      rd_ptr_p0  <= '0;
      ram_cnt_p0 <= '0;
      vld_p1     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_p0 <= wr_ptr_p0 + ONE_C[CB-1:0];
      if (fetch)  rd_ptr_p0 <= rd_ptr_p0 + ONE_C[CB-1:0];

      case ({wr_acc, fetch})
        2'b10:   ram_cnt_p0 <= ram_cnt_p0 + ONE_C;
        2'b01:   ram_cnt_p0 <= ram_cnt_p0 - ONE_C;
        default: ram_cnt_p0 <= ram_cnt_p0;
      endcase

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase

      // the read stage holds its word until the output register can take it
      vld_p1 <= fetch || (vld_p1 && !out_free);

      if (vld_p1 && out_free) begin
        rd_valid <= 1'b1;
        rd_data  <= ram_data_p1;
      end else if (rd_acc) begin
        rd_valid <= 1'b0;
      end

      overflow  <= (overflow  && !err_clear) || (wr_en && full);
      underflow <= (underflow && !err_clear) || (rd_en && !rd_valid);
    end
  end

endmodule
